vga_sprite_engine: RTL and testbench

Parametrised N-channel sprite compositor for the Dino Run VGA path. It sits between the VGA timing counters and the VGA DAC pins. It holds per-sprite position and control registers written over Avalon-MM, double-buffers them so updates land only at frame boundaries, and fetches RGB565 pixels from external synchronous sprite ROMs. It composites the sprites by fixed priority with a transparency key over a programmable background, and reports sprite-0 collisions per frame.

---
 rtl/vga_sprite_engine_pkg.sv | 20 ++
 rtl/vga_sprite_engine_if.sv | 12 +
 rtl/vga_sprite_engine_sprite_channel.sv | 43 ++++
 rtl/vga_sprite_engine.sv | 205 ++++++++++++++++++++
 tb/tb_vga_sprite_engine.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_sprite_engine_pkg.sv
// Shared types, register map and colour helpers for the sprite compositor.
package vga_sprite_pkg;

  typedef logic [15:0] rgb565_t;

  localparam logic [1:0] REG_X    = 2'd0;
  localparam logic [1:0] REG_Y    = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;

  localparam logic [8:0] REG_BG     = 9'h100;
  localparam logic [8:0] REG_STATUS = 9'h101;

  localparam int H_ACTIVE_PX = 640;
  localparam int V_ACTIVE    = 480;

  function automatic logic [23:0] rgb565_to_888(input rgb565_t c);
    return {c[15:11], 3'b000, c[10:5], 2'b00, c[4:0], 3'b000};
  endfunction

endpackage

// File: rtl/vga_sprite_engine_if.sv
// Avalon-MM slave bus used to program the sprite compositor.
interface vga_sprite_engine_if;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [8:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output chipselect, write, read, address, writedata, input readdata);
  modport slave  (input chipselect, write, read, address, writedata, output readdata);
endinterface

// File: rtl/vga_sprite_engine_sprite_channel.sv
// One sprite channel: hit test against the active window, optional horizontal flip, ROM address.
module sprite_channel
  import vga_sprite_pkg::*;
#(
  parameter int SPR_W  = 32,
  parameter int SPR_H  = 32,
  parameter int ROM_AW = 10
) (
  input  logic [9:0]        px,
  input  logic [9:0]        py,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              en,
  input  logic              hflip,
  output logic              hit,
  output logic [ROM_AW-1:0] addr
);

  localparam int CW = $clog2(SPR_W);

  logic [10:0]     px_w, py_w, x_w, y_w, x_end, y_end, dy;
  logic [CW-1:0]   dx, col;
  logic [10+CW:0]  addr_full;

  // 11-bit compares so X+SPR_W cannot wrap; anything past the active area clips
  assign px_w  = {1'b0, px};
  assign py_w  = {1'b0, py};
  assign x_w   = {1'b0, x};
  assign y_w   = {1'b0, y};
  assign x_end = x_w + 11'(SPR_W);
  assign y_end = y_w + 11'(SPR_H);

  assign hit = en && (px_w >= x_w) && (px_w < x_end) && (py_w >= y_w) && (py_w < y_end)
            && (px_w < 11'(H_ACTIVE_PX)) && (py_w < 11'(V_ACTIVE));

  // SPR_W is a power of two, so SPR_W-1-dx is the bitwise inverse of dx
  assign dx        = CW'(px_w - x_w);
  assign dy        = py_w - y_w;
  assign col       = hflip ? ~dx : dx;
  assign addr_full = {dy, {CW{1'b0}}} | {11'b0, col};
  assign addr      = ROM_AW'(addr_full);

endmodule

// File: rtl/vga_sprite_engine.sv
// N-channel sprite compositor: shadow/active register file, 3-stage pixel pipeline, collision status.
module vga_sprite_engine
  import vga_sprite_pkg::*;
#(
  parameter int      NUM_SPRITES = 4,
  parameter int      SPR_W       = 32,
  parameter int      SPR_H       = 32,
  parameter int      ROM_AW      = 10,
  parameter rgb565_t TRANSPARENT = 16'hF81F
) (
  input  logic                          clk,
  input  logic                          reset,
  vga_sprite_engine_if.slave            av,
  input  logic [10:0]                   hcount,
  input  logic [9:0]                    vcount,
  input  logic                          blank_n_in,
  input  logic                          hs_in,
  input  logic                          vs_in,
  output logic [NUM_SPRITES*ROM_AW-1:0] rom_addr,
  input  logic [NUM_SPRITES*16-1:0]     rom_data,
  output logic [7:0]                    VGA_R,
  output logic [7:0]                    VGA_G,
  output logic [7:0]                    VGA_B,
  output logic                          VGA_BLANK_n,
  output logic                          VGA_HS,
  output logic                          VGA_VS
);

  logic [9:0]  x_sh   [NUM_SPRITES];
  logic [9:0]  y_sh   [NUM_SPRITES];
  logic [1:0]  ctrl_sh[NUM_SPRITES];
  logic [9:0]  x_act  [NUM_SPRITES];
  logic [9:0]  y_act  [NUM_SPRITES];
  logic [1:0]  ctrl_act[NUM_SPRITES];
  rgb565_t     bg_sh, bg_act;

  logic        wr_en, rd_en, spr_sel, commit;
  logic [5:0]  idx;
  logic [1:0]  fld;
  logic [31:0] rd_val;

  logic        sticky, status_coll;
  logic [7:0]  frame_cnt;

  logic [NUM_SPRITES-1:0] hit_c, hit_s0, hit_s1, opaque;
  logic [ROM_AW-1:0]      addr_c[NUM_SPRITES];
  logic [2:0]             blank_d, hs_d, vs_d;
  rgb565_t                pix;
  logic                   coll;
  logic [23:0]            rgb_q;

  logic unused_bits;
  assign unused_bits = ^{hcount[0], av.writedata[31:16]};

  assign wr_en   = av.chipselect && av.write;
  assign rd_en   = av.chipselect && av.read;
  assign spr_sel = !av.address[8];
  assign idx     = av.address[7:2];
  assign fld     = av.address[1:0];
  assign commit  = (vcount == 10'(V_ACTIVE)) && (hcount == 11'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        x_sh[i]    <= '0;
        y_sh[i]    <= '0;
        ctrl_sh[i] <= '0;
      end
      bg_sh <= 16'hFFFF;
    end else if (wr_en) begin
      if (spr_sel) begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
          if (idx == 6'(i)) begin
            case (fld)
              REG_X:    x_sh[i]    <= av.writedata[9:0];
              REG_Y:    y_sh[i]    <= av.writedata[9:0];
              REG_CTRL: ctrl_sh[i] <= av.writedata[1:0];
              default:  ;
            endcase
          end
        end
      end else if (av.address == REG_BG) begin
        bg_sh <= av.writedata[15:0];
      end
    end
  end

  // A write landing on the commit cycle is not seen here until the next frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        x_act[i]    <= '0;
        y_act[i]    <= '0;
        ctrl_act[i] <= '0;
      end
      bg_act <= 16'hFFFF;
    end else if (commit) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        x_act[i]    <= x_sh[i];
        y_act[i]    <= y_sh[i];
        ctrl_act[i] <= ctrl_sh[i];
      end
      bg_act <= bg_sh;
    end
  end

  always_comb begin
    rd_val = '0;
    if (spr_sel) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (idx == 6'(i)) begin
          case (fld)
            REG_X:    rd_val = {22'b0, x_sh[i]};
            REG_Y:    rd_val = {22'b0, y_sh[i]};
            REG_CTRL: rd_val = {30'b0, ctrl_sh[i]};
            default:  rd_val = '0;
          endcase
        end
      end
    end else if (av.address == REG_BG) begin
      rd_val = {16'b0, bg_sh};
    end else if (av.address == REG_STATUS) begin
      rd_val = {16'b0, frame_cnt, 7'b0, status_coll};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      av.readdata <= '0;
    else if (rd_en) av.readdata <= rd_val;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky      <= 1'b0;
      status_coll <= 1'b0;
      frame_cnt   <= '0;
    end else if (commit) begin
      status_coll <= sticky;
      sticky      <= 1'b0;
      frame_cnt   <= frame_cnt + 8'd1;
    end else if (coll) begin
      sticky <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_ch
    sprite_channel #(
      .SPR_W (SPR_W),
      .SPR_H (SPR_H),
      .ROM_AW(ROM_AW)
    ) u_ch (
      .px   (hcount[10:1]),
      .py   (vcount),
      .x    (x_act[g]),
      .y    (y_act[g]),
      .en   (ctrl_act[g][0]),
      .hflip(ctrl_act[g][1]),
      .hit  (hit_c[g]),
      .addr (addr_c[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_addr <= '0;
      hit_s0   <= '0;
      hit_s1   <= '0;
      blank_d  <= '0;
      hs_d     <= '1;
      vs_d     <= '1;
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) rom_addr[i*ROM_AW +: ROM_AW] <= addr_c[i];
      hit_s0  <= hit_c;
      hit_s1  <= hit_s0;
      blank_d <= {blank_d[1:0], blank_n_in};
      hs_d    <= {hs_d[1:0], hs_in};
      vs_d    <= {vs_d[1:0], vs_in};
    end
  end

  // Walk from the highest index down so the lowest opaque channel ends up on top
  always_comb begin
    pix    = bg_act;
    opaque = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      opaque[i] = hit_s1[i] && (rom_data[i*16 +: 16] != TRANSPARENT);
      if (opaque[i]) pix = rom_data[i*16 +: 16];
    end
    coll = opaque[0] && (|(opaque >> 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          rgb_q <= '0;
    else if (blank_d[1]) rgb_q <= rgb565_to_888(pix);
    else                rgb_q <= '0;
  end

  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];
  assign VGA_BLANK_n = blank_d[2];
  assign VGA_HS      = hs_d[2];
  assign VGA_VS      = vs_d[2];

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Directed scoreboard bench for vga_sprite_engine: pixels are queued on drive and checked 3 clk later.
module tb_vga_sprite_engine;
  import vga_sprite_pkg::*;

  localparam int N  = 4;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [10:0]     hcount;
  logic [9:0]      vcount;
  logic            blank_n_in, hs_in, vs_in;
  logic [N*AW-1:0] rom_addr;
  logic [N*16-1:0] rom_data;
  logic [7:0]      VGA_R, VGA_G, VGA_B;
  logic            VGA_BLANK_n, VGA_HS, VGA_VS;

  vga_sprite_engine_if bus();

  vga_sprite_engine #(.NUM_SPRITES(N), .SPR_W(32), .SPR_H(32), .ROM_AW(AW), .TRANSPARENT(16'hF81F)) dut (
    .clk(clk), .reset(reset), .av(bus),
    .hcount(hcount), .vcount(vcount),
    .blank_n_in(blank_n_in), .hs_in(hs_in), .vs_in(vs_in),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_BLANK_n(VGA_BLANK_n), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS)
  );

  // Synchronous ROMs: either echo the address or return a fixed colour
  logic [15:0] rom_const [N];
  bit          rom_const_en [N];
  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      rom_data[i*16 +: 16] <= rom_const_en[i] ? rom_const[i] : 16'(rom_addr[i*AW +: AW]);
  end

  typedef struct {
    bit          chk;
    logic [26:0] exp;
    string       tag;
  } sb_t;
  sb_t q[$];

  int   checks = 0;
  int   failures = 0;
  int   frames = 0;
  logic hs_v = 1'b1;
  logic vs_v = 1'b1;

  localparam logic [23:0] BG_WHITE = 24'hF8FCF8;
  localparam logic [23:0] BG_BLUE  = 24'h0000F8;

  function automatic logic [23:0] c888(input logic [15:0] d);
    return {d[15:11], 3'b000, d[10:5], 2'b00, d[4:0], 3'b000};
  endfunction

  function automatic logic [63:0] st(input logic coll);
    return 64'({frames[7:0], 7'b0, coll});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [10:0] hc, input logic [9:0] vc, input logic bl,
                      input bit chk, input logic [23:0] rgb, input string tag);
    sb_t e;
    hcount = hc; vcount = vc; blank_n_in = bl; hs_in = hs_v; vs_in = vs_v;
    e.chk = chk; e.exp = {bl, hs_v, vs_v, rgb}; e.tag = tag;
    q.push_back(e);
    tick();
    if (q.size() == 3) begin
      e = q.pop_front();
      if (e.chk) check(e.tag, 64'({VGA_BLANK_n, VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B}), 64'(e.exp));
    end
  endtask

  task automatic idle();
    step(11'd1500, 10'd500, 1'b0, 1'b0, 24'h0, "idle");
  endtask

  task automatic flush();
    repeat (3) idle();
  endtask

  task automatic pix(input int px, input int py, input logic [23:0] rgb, input string tag);
    step({10'(px), 1'b0}, 10'(py), 1'b1, 1'b1, rgb, tag);
  endtask

  task automatic commit();
    flush();
    step(11'd0, 10'd480, 1'b0, 1'b0, 24'h0, "commit");
    frames++;
  endtask

  task automatic av_write(input logic [8:0] a, input logic [31:0] d, input bit at_commit);
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = d;
    if (at_commit) begin
      step(11'd0, 10'd480, 1'b0, 1'b0, 24'h0, "commit");
      frames++;
    end else begin
      idle();
    end
    bus.chipselect = 1'b0; bus.write = 1'b0;
  endtask

  task automatic av_read(input logic [8:0] a, input logic [63:0] exp, input string tag);
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
    idle();
    bus.chipselect = 1'b0; bus.read = 1'b0;
    check(tag, 64'(bus.readdata), exp);
  endtask

  initial begin
    bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
    bus.address = '0; bus.writedata = '0;
    hcount = 11'd1500; vcount = 10'd500; blank_n_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
    for (int i = 0; i < N; i++) begin
      rom_const[i] = 16'h0;
      rom_const_en[i] = 1'b0;
    end

    #12;
    check("rst_rgb", 64'({VGA_R, VGA_G, VGA_B}), 64'h0);
    check("rst_strobes", 64'({VGA_BLANK_n, VGA_HS, VGA_VS}), 64'b011);
    check("rst_rom_addr", 64'(rom_addr), 64'h0);
    check("rst_readdata", 64'(bus.readdata), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    av_read(REG_STATUS, 64'h0, "status_after_reset");
    av_read(REG_BG, 64'hFFFF, "bg_after_reset");

    // Basic fetch: sprite 0 at (100,100), ROM echoes the address
    av_write(9'd0, 32'd100, 0);
    av_write(9'd1, 32'd100, 0);
    av_write(9'd2, 32'd1, 0);
    av_write(9'd20, 32'd55, 0);
    commit();
    av_read(9'd0, 64'd100, "x_shadow_read");
    av_read(9'd20, 64'd0, "oob_index_read");
    av_read(9'd4, 64'd0, "oob_write_no_alias");
    pix(100, 100, 24'h000000, "fetch_first_px");
    pix(101, 100, 24'h000008, "fetch_addr1");
    pix(131, 131, 24'h007CF8, "fetch_addr1023");
    pix(132, 100, BG_WHITE, "fetch_right_edge_bg");
    pix(100, 132, BG_WHITE, "fetch_bottom_edge_bg");
    pix(99, 100, BG_WHITE, "fetch_left_edge_bg");

    // Double buffering
    av_write(9'd0, 32'd200, 0);
    pix(101, 100, 24'h000008, "db_old_pos_kept");
    pix(201, 100, BG_WHITE, "db_new_pos_not_yet");
    commit();
    pix(101, 100, BG_WHITE, "db_old_pos_gone");
    pix(201, 100, 24'h000008, "db_new_pos");
    flush();
    av_write(9'd0, 32'd300, 1);
    pix(201, 100, 24'h000008, "db_commit_write_deferred");
    pix(301, 100, BG_WHITE, "db_commit_write_not_live");
    commit();
    pix(301, 100, 24'h000008, "db_commit_write_next_frame");
    pix(201, 100, BG_WHITE, "db_prev_pos_gone");
    av_read(9'd0, 64'd300, "db_shadow_read");

    // Priority and transparency: sprites 0 and 1 overlap on columns 110..131
    flush();
    rom_const[0] = 16'h1234; rom_const[1] = 16'h5678; rom_const[2] = 16'h0ABC;
    rom_const_en[0] = 1'b1; rom_const_en[1] = 1'b1; rom_const_en[2] = 1'b1;
    av_write(9'd0, 32'd100, 0);
    av_write(9'd4, 32'd110, 0);
    av_write(9'd5, 32'd100, 0);
    av_write(9'd6, 32'd1, 0);
    av_write(REG_BG, 32'h001F, 0);
    commit();
    pix(115, 105, c888(16'h1234), "prio_s0_wins");
    pix(105, 105, c888(16'h1234), "prio_s0_alone");
    pix(135, 105, c888(16'h5678), "prio_s1_alone");
    flush();
    rom_const[0] = 16'hF81F;
    pix(115, 105, c888(16'h5678), "prio_s0_transparent");
    pix(105, 105, BG_BLUE, "prio_s0_transparent_bg");
    flush();
    rom_const[1] = 16'hF81F;
    pix(115, 105, BG_BLUE, "prio_both_transparent_bg");
    av_read(REG_BG, 64'h001F, "bg_shadow_read");
    av_read(REG_STATUS, st(1'b0), "status_frame_no_coll");

    // Collision: sprite 0 against sprite 2
    flush();
    rom_const[0] = 16'h1234; rom_const[1] = 16'h5678;
    av_write(9'd6, 32'd0, 0);
    av_write(9'd8, 32'd110, 0);
    av_write(9'd9, 32'd100, 0);
    av_write(9'd10, 32'd1, 0);
    commit();
    av_read(REG_STATUS, st(1'b1), "status_prio_frame_coll");
    pix(115, 105, c888(16'h1234), "coll_s0_over_s2");
    commit();
    av_read(REG_STATUS, st(1'b1), "status_coll_s0_s2");
    av_write(9'd8, 32'd400, 0);
    commit();
    av_read(REG_STATUS, st(1'b0), "status_coll_cleared");
    pix(115, 105, c888(16'h1234), "coll_s0_alone");
    pix(405, 105, c888(16'h0ABC), "coll_s2_moved");
    commit();
    av_read(REG_STATUS, 64'h0900, "status_no_overlap_frame9");

    // Clipping at the right edge and no wrap onto the next line
    flush();
    for (int i = 0; i < N; i++) rom_const_en[i] = 1'b0;
    av_write(9'd10, 32'd0, 0);
    av_write(9'd0, 32'd620, 0);
    av_write(9'd1, 32'd200, 0);
    av_write(9'd2, 32'd1, 0);
    commit();
    pix(639, 200, c888(16'd19), "clip_last_visible_col");
    pix(640, 200, BG_BLUE, "clip_px640");
    pix(645, 200, BG_BLUE, "clip_px645");
    pix(0, 201, BG_BLUE, "clip_no_wrap_px0");
    pix(620, 201, c888(16'd32), "clip_second_row");

    // Horizontal flip
    av_write(9'd2, 32'd3, 0);
    commit();
    pix(620, 200, c888(16'd31), "flip_first_col_pix");
    check("flip_rom_addr_at_x", 64'(rom_addr[AW-1:0]), 64'd31);
    pix(639, 200, c888(16'd12), "flip_col19_pix");

    // Asynchronous reset in the middle of a line
    flush();
    av_read(9'd0, 64'd620, "x_before_reset");
    hs_v = 1'b0; vs_v = 1'b0;
    pix(620, 200, c888(16'd31), "pre_reset_col0");
    pix(621, 200, c888(16'd30), "pre_reset_col1");
    pix(622, 200, c888(16'd29), "pre_reset_col2");
    pix(623, 200, c888(16'd28), "pre_reset_col3");
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_rgb", 64'({VGA_R, VGA_G, VGA_B}), 64'h0);
    check("async_rst_strobes", 64'({VGA_BLANK_n, VGA_HS, VGA_VS}), 64'b011);
    check("async_rst_rom_addr", 64'(rom_addr), 64'h0);
    check("async_rst_readdata", 64'(bus.readdata), 64'h0);
    q.delete();
    frames = 0;
    hs_v = 1'b1; vs_v = 1'b1;
    #2;
    reset = 1'b0;
    av_read(9'd0, 64'd0, "x_after_reset");
    av_read(REG_STATUS, 64'h0, "status_after_async_reset");
    av_read(REG_BG, 64'hFFFF, "bg_after_async_reset");
    pix(620, 200, BG_WHITE, "post_reset_bg");
    commit();
    pix(620, 200, BG_WHITE, "post_reset_frame1_bg");
    pix(100, 100, BG_WHITE, "post_reset_frame1_bg_b");
    flush();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
